// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 external SRAM path.
// Imported by the arbiter top and its round-robin picker.
package slc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_AUX = 1'b1
  } port_id_t;

  localparam int SRAM_ADDR_W = 20;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker. Combinational only; the owner of the
// previous grant is held in a register by the parent.
module rr_arb2
  import slc3_mem_pkg::*;
(
  input  logic [1:0] req_i,          // bit 0 = CPU, bit 1 = AUX
  input  port_id_t   last_served_i,
  output logic       gnt_valid_o,
  output port_id_t   gnt_id_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = PORT_CPU;
    if (req_i == 2'b11) begin
      // Contention goes to whichever port did not win last time.
      gnt_id_o = (last_served_i == PORT_CPU) ? PORT_AUX : PORT_CPU;
    end else if (req_i[1]) begin
      gnt_id_o = PORT_AUX;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares the external 1Mx16 SRAM between the CPU and AUX requesters using a
// fixed-length IDLE -> ACCESS -> DONE cycle with a one-cycle ack per port.
module sram_arbiter
  import slc3_mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  // Handshake: req/we/addr/wdata are held stable by the requester until the
  // one-cycle ack; a req still high the cycle after ack is a new request.
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_ack,
  input  logic                   aux_req,
  input  logic                   aux_we,
  input  logic [ADDR_W-1:0]      aux_addr,
  input  logic [DATA_W-1:0]      aux_wdata,
  output logic [DATA_W-1:0]      aux_rdata,
  output logic                   aux_ack,
  output logic                   CE,
  output logic                   UB,
  output logic                   LB,
  output logic                   OE,
  output logic                   WE,
  output logic [SRAM_ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0]      Data_to_SRAM,
  input  logic [DATA_W-1:0]      Data_from_SRAM,
  output logic                   busy,
  output logic                   grant_aux,
  output arb_state_t             dbg_state_o
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  port_id_t          gnt_q, gnt_d;
  port_id_t          last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;

  logic              arb_valid;
  port_id_t          arb_id;

  rr_arb2 u_rr_arb2 (
    .req_i         ({aux_req, cpu_req}),
    .last_served_i (last_q),
    .gnt_valid_o   (arb_valid),
    .gnt_id_o      (arb_id)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      gnt_q       <= PORT_CPU;
      last_q      <= PORT_AUX;  // lets the CPU win the first tie
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    CE          = 1'b1;
    UB          = 1'b1;
    LB          = 1'b1;
    OE          = 1'b1;
    WE          = 1'b1;
    cpu_ack     = 1'b0;
    aux_ack     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = ACCESS;
          gnt_d   = arb_id;
          last_d  = arb_id;
          cnt_d   = CNT_LOAD;
          if (arb_id == PORT_AUX) begin
            we_d    = aux_we;
            addr_d  = aux_addr;
            wdata_d = aux_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ACCESS: begin
        CE = 1'b0;
        UB = 1'b0;
        LB = 1'b0;
        OE = we_q;
        WE = ~we_q;
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (gnt_q == PORT_AUX) aux_rdata_d = Data_from_SRAM;
            else                   cpu_rdata_d = Data_from_SRAM;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cpu_ack = (gnt_q == PORT_CPU);
        aux_ack = (gnt_q == PORT_AUX);
      end
      default: state_d = IDLE;
    endcase
  end

  assign ADDR         = {{(SRAM_ADDR_W - ADDR_W){1'b0}}, addr_q};
  assign Data_to_SRAM = wdata_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign aux_rdata    = aux_rdata_q;
  assign busy         = (state_q != IDLE);
  assign grant_aux    = (gnt_q == PORT_AUX);
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios then random two-port traffic,
// checked every cycle against a transaction-timing reference model.
module tb_sram_arbiter;
  import slc3_mem_pkg::*;

  localparam int WC = 2;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  // ---------------- DUT ----------------
  logic        r_req[2];
  logic        r_we[2];
  logic [15:0] r_addr[2];
  logic [15:0] r_wdata[2];

  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [15:0] cpu_addr, cpu_wdata, aux_addr, aux_wdata;
  logic [15:0] cpu_rdata, aux_rdata;
  logic        cpu_ack, aux_ack;
  logic        CE, UB, LB, OE, WE;
  logic [19:0] ADDR;
  logic [15:0] Data_to_SRAM, Data_from_SRAM;
  logic        busy, grant_aux;
  arb_state_t  dbg_state;

  assign cpu_req   = r_req[0];
  assign cpu_we    = r_we[0];
  assign cpu_addr  = r_addr[0];
  assign cpu_wdata = r_wdata[0];
  assign aux_req   = r_req[1];
  assign aux_we    = r_we[1];
  assign aux_addr  = r_addr[1];
  assign aux_wdata = r_wdata[1];

  sram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(WC)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_rdata(aux_rdata), .aux_ack(aux_ack),
    .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE), .ADDR(ADDR),
    .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
    .busy(busy), .grant_aux(grant_aux), .dbg_state_o(dbg_state)
  );

  // ---------------- external SRAM model (64 words used) ----------------
  logic [15:0] init_mem[64];
  logic [15:0] sram_mem[64];
  logic        sram_ready = 1'b0;

  always @(posedge Clk) begin
    if (!sram_ready) begin
      for (int i = 0; i < 64; i++) sram_mem[i] <= init_mem[i];
      sram_ready <= 1'b1;
    end else if (!CE && !WE) begin
      sram_mem[ADDR[5:0]] <= Data_to_SRAM;
    end
  end
  assign Data_from_SRAM = sram_mem[ADDR[5:0]];

  // ---------------- reference model ----------------
  // m_t: -1 idle, 1..WC strobe cycles, WC+1 ack cycle.
  int          m_t, m_owner, m_last;
  logic        m_we;
  logic [15:0] m_addr, m_wdata;
  logic [15:0] m_rdata[2];
  logic [15:0] ref_mem[64];
  logic [17:0] exp_q[$];   // {port, we, data} in completion order

  int n_pass, n_total;
  bit rand_mode, hold;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic model_reset();
    m_t = -1; m_owner = 0; m_last = 1; m_we = 1'b0;
    m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0;
    exp_q.delete();
    for (int p = 0; p < 2; p++) r_req[p] = 1'b0;
  endtask

  task automatic model_edge();
    if (m_t == -1) begin
      if (r_req[0] || r_req[1]) begin
        if (r_req[0] && r_req[1]) m_owner = 1 - m_last;
        else                      m_owner = r_req[1] ? 1 : 0;
        m_last  = m_owner;
        m_we    = r_we[m_owner];
        m_addr  = r_addr[m_owner];
        m_wdata = r_wdata[m_owner];
        m_t     = 1;
        if (m_we) begin
          ref_mem[m_addr[5:0]] = m_wdata;
          exp_q.push_back({m_owner[0], 1'b1, m_wdata});
        end else begin
          exp_q.push_back({m_owner[0], 1'b0, ref_mem[m_addr[5:0]]});
        end
      end
    end else if (m_t < WC) begin
      m_t++;
    end else if (m_t == WC) begin
      m_t = WC + 1;
      if (!m_we) m_rdata[m_owner] = ref_mem[m_addr[5:0]];
    end else begin
      m_t = -1;
    end
  endtask

  task automatic check_outputs();
    logic        acc;
    logic [17:0] e;
    acc = (m_t >= 1) && (m_t <= WC);
    chk("CE", 32'(CE), 32'(!acc));
    chk("UB", 32'(UB), 32'(!acc));
    chk("LB", 32'(LB), 32'(!acc));
    chk("OE", 32'(OE), 32'(!(acc && !m_we)));
    chk("WE", 32'(WE), 32'(!(acc && m_we)));
    chk("ADDR", 32'(ADDR), {16'h0, m_addr});
    chk("Data_to_SRAM", 32'(Data_to_SRAM), 32'(m_wdata));
    chk("busy", 32'(busy), 32'(m_t != -1));
    chk("grant_aux", 32'(grant_aux), 32'(m_owner));
    chk("cpu_ack", 32'(cpu_ack), 32'((m_t == WC + 1) && (m_owner == 0)));
    chk("aux_ack", 32'(aux_ack), 32'((m_t == WC + 1) && (m_owner == 1)));
    chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rdata[0]));
    chk("aux_rdata", 32'(aux_rdata), 32'(m_rdata[1]));
    if (cpu_ack || aux_ack) begin
      chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_port", 32'(aux_ack), 32'(e[17]));
        if (!e[16]) chk("sb_rdata", 32'(aux_ack ? aux_rdata : cpu_rdata), 32'(e[15:0]));
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_txn(int p, logic we, logic [15:0] addr, logic [15:0] data);
    r_req[p] = 1'b1; r_we[p] = we; r_addr[p] = addr; r_wdata[p] = data;
  endtask

  task automatic new_txn(int p);
    set_txn(p, 1'($urandom_range(1)), 16'($urandom_range(63)), 16'($urandom));
  endtask

  task automatic drive_next();
    bit owner_busy, acked;
    for (int p = 0; p < 2; p++) begin
      owner_busy = (m_t >= 1) && (m_t <= WC) && (m_owner == p);
      acked      = (m_t == WC + 1) && (m_owner == p);
      if (acked) begin
        r_req[p] = 1'b0;
        if (hold || (rand_mode && $urandom_range(1) == 1)) new_txn(p);
      end else if (!r_req[p]) begin
        if (rand_mode && !owner_busy && $urandom_range(9) < 3) new_txn(p);
      end else if (rand_mode && $urandom_range(19) == 0) begin
        r_req[p] = 1'b0;  // abandon pending or in-flight request
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    check_outputs();
    drive_next();
  endtask

  task automatic run_cycles(int n);
    repeat (n) step();
  endtask

  task automatic run_until_idle(int bound);
    int n = 0;
    while ((r_req[0] || r_req[1] || m_t != -1) && n < bound) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < bound), 32'd1);
  endtask

  task automatic apply_reset();
    Reset = 1'b0;
    model_reset();
    repeat (2) begin
      @(posedge Clk);
      #1;
      check_outputs();
    end
    Reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    n_pass = 0; n_total = 0; rand_mode = 0; hold = 0;
    Reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      r_req[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_wdata[p] = '0;
    end
    for (int i = 0; i < 64; i++) begin
      init_mem[i] = 16'($urandom);
      ref_mem[i]  = init_mem[i];
    end
    model_reset();
    repeat (3) begin
      @(posedge Clk);
      #1;
      check_outputs();
    end
    Reset = 1'b1;

    // idle after reset
    run_cycles(10);

    // CPU write then read-back of the same word
    set_txn(0, 1'b1, 16'h0010, 16'hBEEF);
    run_until_idle(20);
    set_txn(0, 1'b0, 16'h0010, 16'h0000);
    run_until_idle(20);
    chk("cpu_readback", 32'(cpu_rdata), 32'h0000BEEF);

    // simultaneous requests straight after reset, held continuously
    apply_reset();
    hold = 1;
    set_txn(0, 1'b1, 16'h0008, 16'h1111);
    set_txn(1, 1'b1, 16'h0009, 16'h2222);
    run_cycles(18);
    hold = 0;
    run_until_idle(40);

    // reset in the second strobe cycle of an AUX read
    set_txn(1, 1'b0, 16'h0005, 16'h0000);
    n = 0;
    while (m_t != 2 && n < 20) begin
      step();
      n++;
    end
    chk("abort_reach_timeout", 32'(n < 20), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("abort_CE", 32'(CE), 32'd1);
    chk("abort_OE", 32'(OE), 32'd1);
    chk("abort_aux_ack", 32'(aux_ack), 32'd0);
    chk("abort_aux_rdata", 32'(aux_rdata), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    model_reset();
    repeat (2) begin
      @(posedge Clk);
      #1;
      check_outputs();
    end
    Reset = 1'b1;
    set_txn(0, 1'b0, 16'h0010, 16'h0000);
    run_until_idle(20);

    // random two-port traffic
    rand_mode = 1;
    run_cycles(500);
    rand_mode = 0;
    run_until_idle(100);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single external 1Mx16 SRAM between two requesters.
  - CPU port: driven by the ISDU/MDR memory path.
  - AUX port: program loader / debug monitor.
- Sequences each access as a fixed-length, multi-cycle SRAM cycle.
- Generates active-low CE/UB/LB/OE/WE, the 20-bit ADDR, and write data toward the tristate buffer.
- Returns read data with a one-cycle ack pulse per port.

Parameters:
- ADDR_W, 16, requester address width; upper SRAM address bits are tied 0.
- DATA_W, 16, data width.
- WAIT_CYCLES, 2, number of cycles strobes are asserted per access; legal range 1..15.

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  last CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- aux_req, aux_we, aux_addr, aux_wdata, aux_rdata, aux_ack  same as CPU set, for the AUX port.
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, active-low.
- ADDR  out  20  SRAM address = {4'b0, granted addr}.
- Data_to_SRAM  out  DATA_W  write data to tristate.
- Data_from_SRAM  in  DATA_W  read data from tristate.
- busy  out  1  high whenever state != IDLE.
- grant_aux  out  1  owner of the current/last access (0 = CPU, 1 = AUX).

Behaviour:
- Reset low:
  - State = IDLE; CE/UB/LB/OE/WE = 1.
  - ADDR, Data_to_SRAM, cpu_rdata, aux_rdata = 0.
  - Both acks = 0; busy = 0; grant_aux = 0; last_served = AUX, so the CPU wins the first tie.
  - Reset asserted mid-access aborts immediately: strobes go high asynchronously and no ack is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is sampled high, grant and go to ACCESS; else stay in IDLE.
  - On grant, register ADDR, we, and Data_to_SRAM from the granted port; set grant_aux; load wait counter = WAIT_CYCLES-1.
- Arbitration:
  - Single request: grant it.
  - Both requesting: grant the port != last_served (round-robin).
  - last_served updates on grant.
- ACCESS:
  - CE = UB = LB = 0.
  - Read: OE = 0, WE = 1. Write: WE = 0, OE = 1.
  - Counter decrements each cycle. At count 0, a read captures Data_from_SRAM into the granted port's rdata on that edge; then go to DONE.
- DONE:
  - All strobes high; granted port's ack = 1 for exactly this cycle; next state IDLE, unconditionally.
- Latency and timing:
  - req seen in IDLE at cycle t → strobes low for cycles t+1 .. t+WAIT_CYCLES → ack at cycle t+WAIT_CYCLES+1.
  - Period per access is WAIT_CYCLES+2 cycles.
  - Strobes are high for at least 2 cycles (DONE, IDLE) between accesses.
- Requester rules:
  - req, we, addr, and wdata must stay stable until ack.
  - A req still high in the cycle after ack is a new request.
  - A req dropped before grant is ignored.
  - A req dropped during ACCESS does not abort: the access completes and ack is still pulsed.
- Output stability:
  - rdata holds its value until the next read completion for that port; a write never changes rdata.
  - ADDR and Data_to_SRAM hold through DONE and IDLE until the next grant.
- Address width: ADDR_W < 20 is zero-extended; no wrap logic.
- No simultaneous acks: at most one ack per cycle.

Decomposition:
- Package slc3_mem_pkg:
  - arb_state_t enum {IDLE, ACCESS, DONE}.
  - port_id_t enum {PORT_CPU = 0, PORT_AUX = 1}.
  - Constant SRAM_ADDR_W = 20.
- Sub-module rr_arb2: two-request round-robin picker.
  - Inputs: req[1:0], last_served.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational; last_served is registered in the parent.

Test Plan:
- Reset release, no requests → all strobes 1, ADDR = 0, busy = 0 for 10 cycles.
- CPU write addr 0x0010 data 0xBEEF, WAIT_CYCLES = 2 → CE = WE = 0 for exactly 2 cycles, OE = 1, ADDR = 0x00010, Data_to_SRAM = 0xBEEF; cpu_ack at t+3.
- CPU read 0x0010, SRAM model returns 0xBEEF → OE = 0 for 2 cycles; cpu_rdata = 0xBEEF in the ack cycle; aux_rdata unchanged.
- Both req high at the same edge after reset → CPU served first; AUX granted at the next IDLE; with both held continuously, grants alternate CPU, AUX, CPU, AUX and acks are spaced 4 cycles apart.
- Reset asserted in the 2nd ACCESS cycle of an AUX read → strobes high immediately, no aux_ack, aux_rdata = 0; after release, a CPU request completes normally.
- WAIT_CYCLES = 1 build: back-to-back CPU reads 0x0000 → 0x0001 → each ack 3 cycles apart, OE low 1 cycle each.
